// File: rtl/aes_pkg.sv
// Shared AES tables and helpers for the reverse key schedule.
// Holds the forward S-box, the round constants and the word-level rotate/substitute helpers.
package aes_pkg;

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Rounds outside 1..10 never reach the datapath usefully; they map to zero.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (r == 4'(i)) begin
                v = RCON[i];
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/aes128_inv_key_step.sv
// One backward step of the AES-128 key schedule: round r key in, round r-1 key out.
// Word 0 of each key occupies bits [127:96].
module aes128_inv_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key,
    input  logic [3:0]   round,
    output logic [127:0] prev_key
);

    logic [31:0] k0, k1, k2, k3;
    logic [31:0] p0, p1, p2, p3;

    assign k0 = key[127:96];
    assign k1 = key[95:64];
    assign k2 = key[63:32];
    assign k3 = key[31:0];

    // Undo the forward XOR chain from the top word down; p3 is then the
    // previous round's last word, which feeds the g() function for p0.
    assign p3 = k3 ^ k2;
    assign p2 = k2 ^ k1;
    assign p1 = k1 ^ k0;
    assign p0 = k0 ^ sub_word(rot_word(p3)) ^ {rcon(round), 24'h000000};

    assign prev_key = {p0, p1, p2, p3};

endmodule

// File: rtl/aes128_inv_key_sched.sv
// Reverse AES-128 key schedule: takes the round-10 key and emits round keys 10/9 down to 0,
// one per output handshake, deriving each from the previous so no key store is needed.
module aes128_inv_key_sched
    import aes_pkg::*;
#(
    parameter logic EMIT_R10 = 1'b0
) (
    input  logic         CLK,
    input  logic         RSTB,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         out_last,
    output logic         busy
);

    state_t       state_reg;
    logic [127:0] key_reg;
    logic [3:0]   cnt_reg;
    logic         in_ready_reg;
    logic         out_valid_reg;
    logic         out_last_reg;
    logic         busy_reg;

    logic [127:0] step_key;
    logic [3:0]   step_round;
    logic [127:0] step_prev;

    // The single step instance serves both the IDLE preload (round 10 -> 9)
    // and the per-handshake derivation in RUN.
    always_comb begin
        step_key   = key_reg;
        step_round = cnt_reg;
        if (state_reg == IDLE) begin
            step_key   = in_key;
            step_round = 4'd10;
        end
    end

    aes128_inv_key_step u_step (
        .key      (step_key),
        .round    (step_round),
        .prev_key (step_prev)
    );

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_reg     <= IDLE;
            key_reg       <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        key_reg       <= EMIT_R10 ? in_key : step_prev;
                        cnt_reg       <= EMIT_R10 ? 4'd10 : 4'd9;
                        state_reg     <= RUN;
                        in_ready_reg  <= 1'b0;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (cnt_reg != 4'd0) begin
                            key_reg      <= step_prev;
                            cnt_reg      <= cnt_reg - 4'd1;
                            out_last_reg <= (cnt_reg == 4'd1);
                        end else begin
                            // Round 0 consumed; hold the last key, reopen input next cycle.
                            state_reg     <= IDLE;
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_key   = key_reg;
    assign out_round = cnt_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;

endmodule
